// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, one bit per
//   clock, LSB first, through a single full-subtractor cell and a borrow flop.
//   Results and flags are registered and held until the next operation's
//   final bit edge (or reset).
//
// Handshake: start is sampled only while idle (busy=0). The edge that sees
//   start=1 in IDLE captures a, b and bin; start while busy is ignored and
//   not queued. done pulses for exactly one cycle, in the same cycle that
//   diff/bout/zero/neg/ovf show the new result. start held high during the
//   done cycle is accepted, so back-to-back operations take WIDTH+1 cycles.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   start     - operation request (sampled in IDLE only)
//   a, b      - minuend / subtrahend, WIDTH bits, captured on accept
//   bin       - borrow-in, captured on accept
//   busy      - high while bits are being processed
//   done      - one-cycle result-valid pulse
//   diff      - registered a - b - bin mod 2^WIDTH
//   bout      - borrow out of the MSB (unsigned a < b + bin)
//   zero      - diff == 0
//   neg       - diff[WIDTH-1]
//   ovf       - signed overflow (borrow into MSB xor borrow out of MSB)
//   dbg_state - current FSM state (0 = IDLE, 1 = RUN)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 most recent result bits; the final bit is combined
  // with these directly into diff, so no extra shift is needed at the end.
  logic [WIDTH-2:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] result_next;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs.
  assign d_bit       = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next     = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign result_next = {d_bit, res_sr};
  assign last_bit    = (state == RUN) && (cnt == CW'(WIDTH - 1));

  assign busy      = (state == RUN);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sr <= a;
          b_sr <= b;
          br   <= bin;
          cnt  <= '0;
        end
      end else begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        br     <= br_next;
        res_sr <= result_next[WIDTH-1:1];
        cnt    <= cnt + CW'(1);
        if (last_bit) begin
          diff <= result_next;
          bout <= br_next;
          zero <= (result_next == '0);
          neg  <= d_bit;
          // On the MSB edge br is the borrow into the MSB.
          ovf  <= br ^ br_next;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Testbench for serial_subtractor with two instances (WIDTH=8 and WIDTH=5)
//   sharing clock and reset. Expected results are pushed to a per-instance
//   queue when an operation is accepted and popped when done pulses.
module tb_serial_subtractor;

  logic clk;
  logic rst;

  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8, zero8, neg8, ovf8, st8;
  logic [7:0] diff8;

  logic       start5, bin5;
  logic [4:0] a5, b5;
  logic       busy5, done5, bout5, zero5, neg5, ovf5, st5;
  logic [4:0] diff5;

  int checks = 0;
  int errors = 0;

  // Packed result: [11:4] diff (zero-extended), [3] bout, [2] zero, [1] neg, [0] ovf
  logic [11:0] exp_q8[$];
  logic [11:0] exp_q5[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] ediff;
    logic       ebout;
    logic       ezero;
    logic       eneg;
    logic       eovf;
  } vec_t;

  vec_t vecs[6];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8),
    .neg(neg8), .ovf(ovf8), .dbg_state(st8)
  );

  serial_subtractor #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .bin(bin5),
    .busy(busy5), .done(done5), .diff(diff5), .bout(bout5), .zero(zero5),
    .neg(neg5), .ovf(ovf5), .dbg_state(st5)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model(input int w, input int av, input int bv, input int bi);
    int m, full, dv, sa, sb, sres;
    logic bo, z, n, o;
    logic [7:0] d8;
    m    = 1 << w;
    full = av - bv - bi;
    bo   = (full < 0);
    dv   = (full + m) % m;
    sa   = (av >= m / 2) ? av - m : av;
    sb   = (bv >= m / 2) ? bv - m : bv;
    sres = sa - sb - bi;
    o    = (sres < -(m / 2)) || (sres > (m / 2 - 1));
    n    = (dv >= m / 2);
    z    = (dv == 0);
    d8   = 8'(dv);
    return {d8, bo, z, n, o};
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    logic [11:0] got;
    logic [11:0] exp;
    if (!rst && done8) begin
      if (exp_q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb8_unexpected_done: got done with diff=0x%0h expected no done", diff8);
      end else begin
        exp = exp_q8.pop_front();
        got = {diff8, bout8, zero8, neg8, ovf8};
        check("sb8_result", 32'(got), 32'(exp));
      end
    end
    if (!rst && done5) begin
      if (exp_q5.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb5_unexpected_done: got done with diff=0x%0h expected no done", diff5);
      end else begin
        exp = exp_q5.pop_front();
        got = {3'b000, diff5, bout5, zero5, neg5, ovf5};
        check("sb5_result", 32'(got), 32'(exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One operation on the selected instance; assumes the instance is idle.
  // Returns with time at #1 after the edge that raised done (done cycle).
  task automatic do_op(input int w, input logic [7:0] av, input logic [7:0] bv, input logic bi);
    int n;
    bit got;
    @(negedge clk);
    if (w == 8) begin
      start8 = 1'b1; a8 = av; b8 = bv; bin8 = bi;
      exp_q8.push_back(model(8, int'(av), int'(bv), int'(bi)));
    end else begin
      start5 = 1'b1; a5 = av[4:0]; b5 = bv[4:0]; bin5 = bi;
      exp_q5.push_back(model(5, int'(av[4:0]), int'(bv[4:0]), int'(bi)));
    end
    @(posedge clk);
    #1;
    check("busy_after_accept", 32'((w == 8) ? busy8 : busy5), 32'd1);
    @(negedge clk);
    start8 = 1'b0;
    start5 = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < 3 * w && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (((w == 8) ? done8 : done5) === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done after %0d", n, w);
    end else begin
      check("done_latency", 32'(n), 32'(w));
      check("busy_in_done_cycle", 32'((w == 8) ? busy8 : busy5), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dcnt;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start5 = 1'b0; a5 = '0; b5 = '0; bin5 = 1'b0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_flags", 32'({bout8, zero8, neg8, ovf8}), 32'd0);
    check("rst_state", 32'(st8), 32'd0);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      do_op(8, vecs[i].a, vecs[i].b, vecs[i].bin);
      check("vec_diff", 32'(diff8), 32'(vecs[i].ediff));
      check("vec_bout", 32'(bout8), 32'(vecs[i].ebout));
      check("vec_zero", 32'(zero8), 32'(vecs[i].ezero));
      check("vec_neg",  32'(neg8),  32'(vecs[i].eneg));
      check("vec_ovf",  32'(ovf8),  32'(vecs[i].eovf));
    end

    // Start while busy is ignored; operand change mid-run has no effect
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h20; b8 = 8'h01; bin8 = 1'b0;
    exp_q8.push_back(model(8, 32'h20, 32'h01, 0));
    @(posedge clk);                 // E0
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);                 // E1
    @(posedge clk);                 // E2
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b1;
    @(posedge clk);                 // E3 sees start while busy
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h55;
    dcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (done8) begin
        dcnt++;
        check("busy_start_diff", 32'(diff8), 32'h1F);
      end
    end
    check("busy_start_done_count", 32'(dcnt), 32'd1);

    // start held high: accepted in each done cycle, done every 9 cycles
    for (int k = 0; k < 3; k++) begin
      logic [7:0] ha, hb;
      int bad;
      ha = (k == 0) ? 8'h40 : (k == 1) ? 8'h01 : 8'h9A;
      hb = (k == 0) ? 8'h11 : (k == 1) ? 8'h02 : 8'h13;
      @(negedge clk);
      start8 = 1'b1; a8 = ha; b8 = hb; bin8 = 1'b0;
      exp_q8.push_back(model(8, int'(ha), int'(hb), 0));
      @(posedge clk);               // accept edge
      #1;
      bad = 0;
      for (int j = 1; j <= 8; j++) begin
        @(posedge clk);
        #1;
        if (j < 8 && done8 !== 1'b0) bad++;
        if (j == 8) check("hold_done_at_9", 32'(done8), 32'd1);
      end
      check("hold_no_early_done", 32'(bad), 32'd0);
    end
    @(negedge clk);
    start8 = 1'b0;

    // Reset at E4 of an operation: aborts, clears held results
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0;
    @(posedge clk);                 // E0
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);      // E1..E3
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);                 // E4 with reset
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_diff", 32'(diff8), 32'd0);
    check("midrst_flags", 32'({bout8, zero8, neg8, ovf8}), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done8) dcnt++;
    end
    check("midrst_no_done", 32'(dcnt), 32'd0);
    do_op(8, 8'h09, 8'h04, 1'b0);
    check("after_rst_diff", 32'(diff8), 32'h05);

    // Random sweeps
    for (int i = 0; i < 1000; i++) begin
      do_op(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 1000; i++) begin
      do_op(5, 8'($urandom_range(0, 31)), 8'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb8_drained", 32'(exp_q8.size()), 32'd0);
    check("sb5_drained", 32'(exp_q5.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
